mux_scan_ctrl: RTL and testbench

MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

---
 rtl/mux_scan_ctrl.sv | 153 +++++++++++++++
 tb/tb_mux_scan_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_ctrl.sv
// ---------------------------------------------------------------------------
// mux_scan_ctrl
// Steps the select lines of a downstream 8:1 analog/digital mux across the
// enabled channels. For each channel it waits DWELL settle cycles, then
// captures the mux output into the matching bit of the sample register.
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   start        in   begin a scan (honoured only in IDLE)
//   abort        in   cancel the scan in progress
//   chan_mask    in   [7:0] channels to scan, bit i = channel i
//   mux_out      in   data output of the downstream mux
//   sel          out  [2:0] mux select
//   sample       out  [7:0] captured values, bit i = channel i
//   sample_valid out  sample holds a complete scan result
//   busy         out  scan in progress (SETTLE or CAPTURE)
//   done         out  one-cycle pulse at scan completion
// ---------------------------------------------------------------------------
//  state     | meaning
//  S_IDLE    | waiting for start, outputs hold last result
//  S_SETTLE  | mux select applied, counting DWELL settle cycles
//  S_CAPTURE | one cycle, mux output written into sample[sel]
//  S_DONE    | one cycle with done=1, then back to IDLE
// ---------------------------------------------------------------------------
module mux_scan_ctrl #(
    parameter int unsigned DWELL = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] chan_mask,
    input  logic       mux_out,
    output logic [2:0] sel,
    output logic [7:0] sample,
    output logic       sample_valid,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t     r_state;
    logic [3:0] r_cnt;
    logic [7:0] r_mask;
    logic [2:0] r_sel;
    logic [7:0] r_sample;
    logic       r_valid;
    logic       r_busy;
    logic       r_done;

    logic [3:0] w_first;   // {found, index} lowest set bit of chan_mask
    logic [3:0] w_next;    // {found, index} next set bit of r_mask above r_sel

    // Lowest set bit of m at index >= lo; bit 3 of the result flags a hit.
    // lo is 4 bits so that lo=8 (nothing above channel 7) finds nothing.
    function automatic logic [3:0] find_from(input logic [7:0] m, input logic [3:0] lo);
        logic [3:0] res;
        res = 4'b0000;
        for (int i = 7; i >= 0; i--) begin
            if (m[i] && (4'(i) >= lo))
                res = {1'b1, 3'(i)};
        end
        return res;
    endfunction

    always_comb begin
        w_first = find_from(chan_mask, 4'd0);
        w_next  = find_from(r_mask, {1'b0, r_sel} + 4'd1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_mask   <= 8'h00;
            r_sel    <= 3'b000;
            r_sample <= 8'h00;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sample <= 8'h00;
                        if (chan_mask != 8'h00) begin
                            r_mask  <= chan_mask;
                            r_sel   <= w_first[2:0];
                            r_cnt   <= 4'd0;
                            r_valid <= 1'b0;
                            r_busy  <= 1'b1;
                            r_state <= S_SETTLE;
                        end else begin
                            // Empty scan: result is trivially complete.
                            r_valid <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_SETTLE: begin
                    if (abort) begin
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                        if (r_cnt == 4'(DWELL - 1))
                            r_state <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (abort) begin
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_sample[r_sel] <= mux_out;
                        if (w_next[3]) begin
                            r_sel   <= w_next[2:0];
                            r_cnt   <= 4'd0;
                            r_state <= S_SETTLE;
                        end else begin
                            r_valid <= 1'b1;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign sel          = r_sel;
    assign sample       = r_sample;
    assign sample_valid = r_valid;
    assign busy         = r_busy;
    assign done         = r_done;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mux_scan_ctrl
// Scoreboard bench for mux_scan_ctrl (DWELL=2). The driver issues scans and
// pushes the expected end-of-scan observation (event kind, cycle, sample,
// sample_valid, sel) computed from the scan timeline. The monitor pops and
// compares whenever the DUT ends a scan: done pulse, or busy dropping
// without done (abort / reset). mux_out follows the pattern PAT[sel].
// ---------------------------------------------------------------------------
module tb_mux_scan_ctrl;

    localparam int D = 2;

    localparam int K_DONE  = 0;
    localparam int K_ABORT = 1;
    localparam int K_RESET = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] chan_mask = 8'h00;
    logic       mux_out;
    logic [2:0] sel;
    logic [7:0] sample;
    logic       sample_valid;
    logic       busy;
    logic       done;

    logic [7:0] pat = 8'h00;

    mux_scan_ctrl #(.DWELL(D)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .chan_mask    (chan_mask),
        .mux_out      (mux_out),
        .sel          (sel),
        .sample       (sample),
        .sample_valid (sample_valid),
        .busy         (busy),
        .done         (done)
    );

    assign mux_out = pat[sel];

    always #5 clk = ~clk;

    int edges = 0;
    always @(posedge clk) edges <= edges + 1;

    typedef struct {
        int         kind;
        int         t_edges;
        logic [7:0] samp;
        logic       valid;
        logic [2:0] sel;
        logic       busy_allowed;
    } exp_t;

    exp_t q[$];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // ---------------- monitor ----------------
    logic mon_en    = 1'b0;
    logic prev_busy = 1'b0;
    logic busy_seen = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (done || (prev_busy && !busy)) begin
                if (q.size() == 0) begin
                    chk("unexpected_event", 32'(done), 32'd2);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("event_kind", done ? K_DONE : K_ABORT_OR_RESET(e.kind), e.kind);
                    chk("event_cycle", edges, e.t_edges);
                    chk("sample", {24'd0, sample}, {24'd0, e.samp});
                    chk("sample_valid", {31'd0, sample_valid}, {31'd0, e.valid});
                    chk("sel", {29'd0, sel}, {29'd0, e.sel});
                    if (!e.busy_allowed)
                        chk("busy_never_set", {31'd0, busy_seen}, 32'd0);
                end
                busy_seen = busy;
            end else begin
                busy_seen = busy_seen | busy;
            end
            prev_busy = busy;
        end
    end

    // A drop of busy without done is either an abort or a reset; which one is
    // told apart by the reset side effects (sel and sample cleared).
    function automatic int K_ABORT_OR_RESET(input int exp_kind);
        if (exp_kind == K_RESET && sel == 3'b000 && sample == 8'h00)
            return K_RESET;
        else if (exp_kind == K_RESET)
            return K_ABORT;
        else
            return K_ABORT;
    endfunction

    // ---------------- driver / reference model ----------------
    logic [2:0] last_sel = 3'b000;

    // mode: 0 full scan, 1 abort at cycle 'at', 2 reset at cycle 'at'.
    // extra: cycle of a second start pulse (0 = none).
    task automatic run_scan(input logic [7:0] m, input logic [7:0] p,
                            input int mode, input int at, input int extra);
        int   idx[8];
        int   n;
        int   s;
        int   t_end;
        int   lend;
        int   k;
        exp_t e;
        n = 0;
        for (int i = 0; i < 8; i++) if (m[i]) begin idx[n] = i; n++; end
        if (n == 0) mode = 0;

        e.busy_allowed = (n != 0);
        if (mode == 0) begin
            t_end   = (n == 0) ? 1 : n * (D + 1) + 1;
            e.kind  = K_DONE;
            e.samp  = p & m;
            e.valid = 1'b1;
            e.sel   = (n == 0) ? last_sel : 3'(idx[n-1]);
            lend    = t_end;
        end else if (mode == 1) begin
            k       = at / (D + 1);        // channels fully captured before abort
            t_end   = at + 1;
            e.kind  = K_ABORT;
            e.samp  = 8'h00;
            for (int i = 0; i < k; i++) e.samp[idx[i]] = p[idx[i]];
            e.valid = 1'b0;
            e.sel   = 3'(idx[k]);
            lend    = at;
        end else begin
            t_end   = at + 1;
            e.kind  = K_RESET;
            e.samp  = 8'h00;
            e.valid = 1'b0;
            e.sel   = 3'b000;
            lend    = at;
        end
        last_sel = e.sel;

        @(negedge clk);
        s = edges;
        e.t_edges = s + t_end;
        q.push_back(e);
        pat = p; chan_mask = m; start = 1'b1; abort = 1'b0; rst = 1'b0;
        for (int c = 1; c <= lend; c++) begin
            @(negedge clk);
            start     = (c == extra);
            abort     = (mode == 1) && (c == at);
            rst       = (mode == 2) && (c == at);
            chan_mask = 8'($urandom);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            start = 1'b0; abort = 1'b0; rst = 1'b0;
        end
    endtask

    initial begin : main
        int         mode;
        int         at;
        int         extra;
        int         n;
        logic [7:0] m;
        logic [7:0] p;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_sel", {29'd0, sel}, 32'd0);
        chk("rst_sample", {24'd0, sample}, 32'd0);
        chk("rst_valid", {31'd0, sample_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        prev_busy = busy;
        mon_en = 1'b1;
        idle(2);

        // Directed scenarios
        run_scan(8'hFF, 8'hA5, 0, 0, 0);
        idle(1);
        run_scan(8'h81, 8'hFF, 0, 0, 0);
        run_scan(8'h00, 8'h5A, 0, 0, 0);     // back to back
        idle(2);
        run_scan(8'hFF, 8'h3C, 1, 8, 0);
        run_scan(8'hFF, 8'hC3, 2, 5, 3);
        idle(1);
        run_scan(8'hFF, 8'h96, 0, 0, 4);     // start while busy ignored

        // Randomized scans
        for (int it = 0; it < 60; it++) begin
            m = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
            p = 8'($urandom);
            n = $countones(m);
            mode = $urandom_range(0, 9);
            mode = (mode < 6 || n == 0) ? 0 : (mode < 9 ? 1 : 2);
            if (mode == 1)
                at = $urandom_range(0, n - 1) * (D + 1) + $urandom_range(1, D);
            else if (mode == 2)
                at = $urandom_range(1, n * (D + 1));
            else
                at = 0;
            extra = 0;
            if ($urandom_range(0, 1) == 1) begin
                if (mode == 0) extra = $urandom_range(1, (n == 0) ? 1 : n * (D + 1) + 1);
                else           extra = $urandom_range(1, at);
            end
            run_scan(m, p, mode, at, extra);
            idle($urandom_range(0, 2));
        end

        idle(4);
        chk("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1);
    end

endmodule
